// File: rtl/hazard_scoreboard.sv
// Countdown-scoreboard hazard unit between ID and ID/EX: RAW, WAW and iterative-multiplier
// structural stalls for the ID instruction, with pipeline freeze and ID flush.
module hazard_scoreboard #(
  parameter int unsigned NREG     = 32,
  parameter int unsigned ALU_LAT  = 1,
  parameter int unsigned LD_LAT   = 2,
  parameter int unsigned MUL_LAT  = 3,
  parameter int unsigned MUL_PIPE = 0,
  localparam int unsigned RW      = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [RW-1:0] rs1,
  input  logic [RW-1:0] rs2,
  input  logic          use_rs1,
  input  logic          use_rs2,
  input  logic [RW-1:0] rd,
  input  logic          reg_write,
  input  logic          mem_read,
  input  logic          mul,
  input  logic          jb,
  input  logic          freeze,
  input  logic          flush,
  output logic          hazard_stall,
  output logic          issue,
  output logic          stall_raw,
  output logic          stall_waw,
  output logic          stall_struct,
  output logic          mul_busy
);

  localparam int unsigned MaxAluLd = (ALU_LAT > LD_LAT) ? ALU_LAT : LD_LAT;
  localparam int unsigned MaxLat   = (MaxAluLd > MUL_LAT) ? MaxAluLd : MUL_LAT;
  localparam int unsigned CW       = $clog2(MaxLat + 1);

  localparam logic [CW-1:0] AluLat   = CW'(ALU_LAT);
  localparam logic [CW-1:0] LdLat    = CW'(LD_LAT);
  localparam logic [CW-1:0] MulLat   = CW'(MUL_LAT);
  localparam logic [CW-1:0] MulBusy  = CW'(MUL_LAT - 1);
  localparam logic          MulIter  = (MUL_PIPE == 0);

  // Entry 0 is not stored; x0 always reads as ready.
  logic [CW-1:0] rem_q [1:NREG-1];
  logic [CW-1:0] rem_d [1:NREG-1];
  logic [CW-1:0] rem_all [NREG];
  logic [CW-1:0] busy_q, busy_d;

  logic [CW-1:0] lat_class;
  logic [CW-1:0] need_thr;
  logic [CW-1:0] rem_rs1, rem_rs2, rem_rd;
  logic          raw_hit, waw_hit, struct_hit;
  logic          rd_tracked;
  logic          sb_write, mul_start;

  always_comb begin
    rem_all[0] = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      rem_all[r] = rem_q[r];
    end
  end

  assign rem_rs1 = rem_all[rs1];
  assign rem_rs2 = rem_all[rs2];
  assign rem_rd  = rem_all[rd];

  always_comb begin
    if (mem_read) begin
      lat_class = LdLat;
    end else if (mul) begin
      lat_class = MulLat;
    end else begin
      lat_class = AluLat;
    end
  end

  // Branches/jumps resolve operands in ID, so they need the value one cycle earlier.
  assign need_thr   = jb ? '0 : CW'(1);
  assign rd_tracked = reg_write && (rd != '0);

  assign raw_hit    = id_valid && ((use_rs1 && (rem_rs1 > need_thr)) ||
                                   (use_rs2 && (rem_rs2 > need_thr)));
  assign waw_hit    = id_valid && rd_tracked && (rem_rd > lat_class);
  assign struct_hit = id_valid && mul && MulIter && (busy_q != '0);

  assign stall_raw    = raw_hit && !flush;
  assign stall_waw    = waw_hit && !flush;
  assign stall_struct = struct_hit && !flush;
  assign hazard_stall = stall_raw || stall_waw || stall_struct;
  assign issue        = id_valid && !hazard_stall && !freeze && !flush;
  assign mul_busy     = (busy_q != '0);

  assign sb_write  = issue && rd_tracked;
  assign mul_start = issue && mul && MulIter;

  always_comb begin
    for (int unsigned r = 1; r < NREG; r++) begin
      rem_d[r] = rem_q[r];
      if (!freeze) begin
        if (rem_q[r] != '0) begin
          rem_d[r] = rem_q[r] - CW'(1);
        end
        if (sb_write && (rd == RW'(r))) begin
          rem_d[r] = lat_class;
        end
      end
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (!freeze) begin
      if (busy_q != '0) begin
        busy_d = busy_q - CW'(1);
      end
      if (mul_start) begin
        busy_d = MulBusy;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 1; r < NREG; r++) begin
        rem_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int unsigned r = 1; r < NREG; r++) begin
        rem_q[r] <= rem_d[r];
      end
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed stall scenarios plus randomized traffic
// against a timestamp-based model (each register has an absolute "ready at" time).
module tb_hazard_scoreboard;
  localparam int ALU = 1;
  localparam int LD  = 2;
  localparam int ML  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_valid = 1'b0, use_rs1 = 1'b0, use_rs2 = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic       reg_write = 1'b0, mem_read = 1'b0, mul = 1'b0, jb = 1'b0;
  logic       freeze = 1'b0, flush = 1'b0;
  logic       hazard_stall, issue, stall_raw, stall_waw, stall_struct, mul_busy;
  logic       hazard_stall_p, issue_p, stall_raw_p, stall_waw_p, stall_struct_p, mul_busy_p;

  int checks = 0;
  int failures = 0;

  // Model: 'now' counts unfrozen edges; a register is pending while ready_at > now.
  int now;
  int ready_at [32];
  int busy_until;
  logic e_raw, e_waw, e_st, e_hs, e_issue, e_mb;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NREG(32), .ALU_LAT(ALU), .LD_LAT(LD), .MUL_LAT(ML), .MUL_PIPE(0)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .rs1(rs1), .rs2(rs2),
    .use_rs1(use_rs1), .use_rs2(use_rs2), .rd(rd), .reg_write(reg_write),
    .mem_read(mem_read), .mul(mul), .jb(jb), .freeze(freeze), .flush(flush),
    .hazard_stall(hazard_stall), .issue(issue), .stall_raw(stall_raw),
    .stall_waw(stall_waw), .stall_struct(stall_struct), .mul_busy(mul_busy)
  );

  hazard_scoreboard #(.NREG(32), .ALU_LAT(ALU), .LD_LAT(LD), .MUL_LAT(ML), .MUL_PIPE(1)) dut_p (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .rs1(rs1), .rs2(rs2),
    .use_rs1(use_rs1), .use_rs2(use_rs2), .rd(rd), .reg_write(reg_write),
    .mem_read(mem_read), .mul(mul), .jb(jb), .freeze(freeze), .flush(flush),
    .hazard_stall(hazard_stall_p), .issue(issue_p), .stall_raw(stall_raw_p),
    .stall_waw(stall_waw_p), .stall_struct(stall_struct_p), .mul_busy(mul_busy_p)
  );

  function automatic int rem_m(int r);
    if (r == 0) return 0;
    return (ready_at[r] > now) ? ready_at[r] - now : 0;
  endfunction

  function automatic int lat_m();
    return mem_read ? LD : (mul ? ML : ALU);
  endfunction

  function automatic void model_reset();
    now = 0;
    busy_until = 0;
    for (int i = 0; i < 32; i++) ready_at[i] = 0;
  endfunction

  function automatic void model_eval();
    int thr;
    thr   = jb ? 0 : 1;
    e_raw = id_valid && ((use_rs1 && rem_m(int'(rs1)) > thr) ||
                         (use_rs2 && rem_m(int'(rs2)) > thr));
    e_waw = id_valid && reg_write && (rd != 0) && (rem_m(int'(rd)) > lat_m());
    e_st  = id_valid && mul && (busy_until > now);
    if (flush) begin
      e_raw = 1'b0; e_waw = 1'b0; e_st = 1'b0;
    end
    e_hs    = e_raw || e_waw || e_st;
    e_issue = id_valid && !e_hs && !freeze && !flush;
    e_mb    = busy_until > now;
  endfunction

  function automatic void model_step();
    if (!freeze) begin
      now = now + 1;
      if (e_issue && reg_write && rd != 0) ready_at[rd] = now + lat_m();
      if (e_issue && mul) busy_until = now + ML - 1;
    end
  endfunction

  task automatic clk_edge();
    model_eval();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  task automatic set_instr(input int r1, input int u1, input int r2, input int u2, input int d,
                           input int rw, input int mr, input int ml, input int j);
    id_valid = 1'b1;
    rs1 = 5'(r1); use_rs1 = (u1 != 0);
    rs2 = 5'(r2); use_rs2 = (u2 != 0);
    rd = 5'(d); reg_write = (rw != 0); mem_read = (mr != 0); mul = (ml != 0); jb = (j != 0);
    freeze = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input int n);
    id_valid = 1'b0; freeze = 1'b0; flush = 1'b0;
    for (int i = 0; i < n; i++) clk_edge();
  endtask

  // Returns the number of stall cycles before issue, or -1 if it never issued.
  task automatic run_until_issue(output int n);
    n = -1;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (issue === 1'b1) begin
        n = i;
        clk_edge();
        return;
      end
      clk_edge();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    set_instr(5, 1, 6, 1, 7, 1, 0, 1, 0);
    #1;
    checks++; if (hazard_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b want=0", hazard_stall); end
    checks++; if ({stall_raw, stall_waw, stall_struct} !== 3'b000) begin failures++; $display("FAIL reset_causes got=%b want=000", {stall_raw, stall_waw, stall_struct}); end
    checks++; if (mul_busy !== 1'b0) begin failures++; $display("FAIL reset_mul_busy got=%b want=0", mul_busy); end
    checks++; if (issue !== 1'b1) begin failures++; $display("FAIL reset_issue got=%b want=1", issue); end
    freeze = 1'b1;
    #1;
    checks++; if (issue !== 1'b0) begin failures++; $display("FAIL reset_issue_frozen got=%b want=0", issue); end
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_load_use();
    int n;
    idle(4);
    set_instr(1, 1, 0, 0, 5, 1, 1, 0, 0);
    #1;
    checks++; if (issue !== 1'b1) begin failures++; $display("FAIL lu_producer_issue got=%b want=1", issue); end
    clk_edge();
    set_instr(5, 1, 1, 1, 6, 1, 0, 0, 0);
    #1;
    checks++; if (hazard_stall !== 1'b1 || stall_raw !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b%b want=11", hazard_stall, stall_raw); end
    checks++; if (issue !== 1'b0) begin failures++; $display("FAIL lu_issue_held got=%b want=0", issue); end
    clk_edge();
    #1;
    checks++; if (issue !== 1'b1 || hazard_stall !== 1'b0) begin failures++; $display("FAIL lu_release got=%b%b want=10", issue, hazard_stall); end
    clk_edge();
    idle(1);
  endtask

  task automatic test_stall_table();
    // producer: 0 alu, 1 load, 2 mul; consumer: 0 alu reads x5, 1 branch on x5, 2 independent
    int prod [7] = '{0, 0, 1, 1, 2, 2, 1};
    int cons [7] = '{0, 1, 0, 1, 0, 1, 2};
    int expn [7] = '{0, 1, 1, 2, ML - 1, ML, 0};
    int n;
    for (int k = 0; k < 7; k++) begin
      idle(5);
      set_instr(1, 1, 2, 1, 5, 1, (prod[k] == 1) ? 1 : 0, (prod[k] == 2) ? 1 : 0, 0);
      #1;
      checks++; if (issue !== 1'b1) begin failures++; $display("FAIL table%0d_producer got=%b want=1", k, issue); end
      clk_edge();
      if (cons[k] == 0) set_instr(5, 1, 1, 1, 6, 1, 0, 0, 0);
      else if (cons[k] == 1) set_instr(5, 1, 0, 1, 0, 0, 0, 0, 1);
      else set_instr(0, 1, 0, 1, 6, 1, 0, 0, 0);
      run_until_issue(n);
      checks++; if (n != expn[k]) begin failures++; $display("FAIL table%0d_stalls got=%0d want=%0d", k, n, expn[k]); end
    end
    idle(1);
  endtask

  task automatic test_mul_struct();
    int n;
    idle(5);
    set_instr(1, 1, 2, 1, 7, 1, 0, 1, 0);
    #1;
    checks++; if (issue !== 1'b1 || issue_p !== 1'b1) begin failures++; $display("FAIL mul1_issue got=%b%b want=11", issue, issue_p); end
    clk_edge();
    set_instr(3, 1, 4, 1, 8, 1, 0, 1, 0);
    #1;
    checks++; if (stall_struct !== 1'b1 || mul_busy !== 1'b1) begin failures++; $display("FAIL mul2_struct got=%b%b want=11", stall_struct, mul_busy); end
    checks++; if (issue_p !== 1'b1 || stall_struct_p !== 1'b0 || mul_busy_p !== 1'b0) begin failures++; $display("FAIL mulpipe_nostall got=%b%b%b want=100", issue_p, stall_struct_p, mul_busy_p); end
    run_until_issue(n);
    checks++; if (n != ML - 1) begin failures++; $display("FAIL mul2_stalls got=%0d want=%0d", n, ML - 1); end
    idle(1);
  endtask

  task automatic test_waw();
    int n;
    idle(5);
    set_instr(1, 1, 2, 1, 7, 1, 0, 1, 0);
    clk_edge();
    set_instr(0, 1, 0, 0, 7, 1, 0, 0, 0);
    #1;
    checks++; if (stall_waw !== 1'b1 || stall_raw !== 1'b0) begin failures++; $display("FAIL waw_flag got=%b%b want=10", stall_waw, stall_raw); end
    run_until_issue(n);
    checks++; if (n != 2) begin failures++; $display("FAIL waw_stalls got=%0d want=2", n); end
    set_instr(7, 1, 0, 1, 0, 0, 0, 0, 1);
    run_until_issue(n);
    checks++; if (n != 1) begin failures++; $display("FAIL waw_newlat got=%0d want=1", n); end
    idle(1);
  endtask

  task automatic test_freeze();
    int n;
    idle(5);
    set_instr(1, 1, 0, 0, 5, 1, 1, 0, 0);
    clk_edge();
    set_instr(5, 1, 1, 1, 6, 1, 0, 0, 0);
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (hazard_stall !== 1'b1 || issue !== 1'b0) begin failures++; $display("FAIL freeze_cyc%0d got=%b%b want=10", i, hazard_stall, issue); end
      clk_edge();
    end
    freeze = 1'b0;
    run_until_issue(n);
    checks++; if (n != 1) begin failures++; $display("FAIL freeze_stalls_after got=%0d want=1", n); end
    idle(1);
  endtask

  task automatic test_flush();
    int n;
    idle(5);
    set_instr(1, 1, 0, 0, 5, 1, 1, 0, 0);
    clk_edge();
    set_instr(5, 1, 1, 1, 6, 1, 0, 0, 0);
    flush = 1'b1;
    #1;
    checks++; if ({hazard_stall, stall_raw, issue} !== 3'b000) begin failures++; $display("FAIL flush_bubble got=%b want=000", {hazard_stall, stall_raw, issue}); end
    clk_edge();
    set_instr(6, 1, 6, 1, 7, 1, 0, 0, 1);
    run_until_issue(n);
    checks++; if (n != 0) begin failures++; $display("FAIL flush_no_entry got=%0d want=0", n); end
    idle(5);
    set_instr(1, 1, 2, 1, 9, 1, 0, 1, 0);
    flush = 1'b1;
    clk_edge();
    set_instr(3, 1, 4, 1, 10, 1, 0, 1, 0);
    #1;
    checks++; if (mul_busy !== 1'b0 || stall_struct !== 1'b0) begin failures++; $display("FAIL flush_mul_busy got=%b%b want=00", mul_busy, stall_struct); end
    idle(1);
  endtask

  task automatic test_reset_mid();
    idle(5);
    set_instr(1, 1, 2, 1, 7, 1, 0, 1, 0);
    clk_edge();
    id_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (mul_busy !== 1'b0) begin failures++; $display("FAIL rstmid_mul_busy got=%b want=0", mul_busy); end
    @(negedge clk);
    rst_n = 1'b1;
    set_instr(7, 1, 7, 1, 8, 1, 0, 0, 0);
    #1;
    checks++; if (issue !== 1'b1 || hazard_stall !== 1'b0) begin failures++; $display("FAIL rstmid_issue got=%b%b want=10", issue, hazard_stall); end
    clk_edge();
    idle(1);
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      id_valid  = ($urandom_range(0, 9) < 8);
      rs1       = 5'($urandom_range(0, 7));
      rs2       = 5'($urandom_range(0, 7));
      use_rs1   = $urandom_range(0, 3) != 0;
      use_rs2   = $urandom_range(0, 1) != 0;
      rd        = 5'($urandom_range(0, 7));
      reg_write = $urandom_range(0, 3) != 0;
      mem_read  = $urandom_range(0, 3) == 0;
      mul       = $urandom_range(0, 3) == 0;
      jb        = $urandom_range(0, 4) == 0;
      freeze    = $urandom_range(0, 9) == 0;
      flush     = $urandom_range(0, 9) == 0;
      #1;
      model_eval();
      checks++; if ({hazard_stall, stall_raw, stall_waw, stall_struct, issue, mul_busy} !==
                    {e_hs, e_raw, e_waw, e_st, e_issue, e_mb}) begin
        failures++;
        $display("FAIL rand_cyc%0d got=%b want=%b", c,
                 {hazard_stall, stall_raw, stall_waw, stall_struct, issue, mul_busy},
                 {e_hs, e_raw, e_waw, e_st, e_issue, e_mb});
      end
      checks++; if (stall_struct_p !== 1'b0 || mul_busy_p !== 1'b0) begin failures++; $display("FAIL rand_pipe_cyc%0d got=%b%b want=00", c, stall_struct_p, mul_busy_p); end
      clk_edge();
    end
    idle(1);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_use();
    test_stall_table();
    test_mul_struct();
    test_waw();
    test_freeze();
    test_flush();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
